// File: rtl/pipelined_right_barrel_shifter_if.sv
// Push/pop handshake bundle for pipelined_right_barrel_shifter.
// A word moves on a rising clk edge where its valid and ready are both 1; valid never waits on ready.
interface pipelined_right_barrel_shifter_if #(
    parameter int DATA_WIDTH  = 22,
    parameter int SHIFT_WIDTH = 5
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [DATA_WIDTH-1:0]  data_i;
    logic [SHIFT_WIDTH-1:0] shifts_i;
    logic                   arith_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_WIDTH-1:0]  data_o;

    modport master (
        output in_valid_i,
        output data_i,
        output shifts_i,
        output arith_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  data_o
    );

    modport slave (
        input  in_valid_i,
        input  data_i,
        input  shifts_i,
        input  arith_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output data_o
    );
endinterface

// File: rtl/pipelined_right_barrel_shifter.sv
// Pipelined right barrel shifter: stage k applies shift bit k, one global stall enable.
// Define RIGHT_SHIFT_ROUND_EN for round-half-up results (guard bit carried through the stages).
module pipelined_right_barrel_shifter #(
    parameter int DATA_WIDTH  = 22,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    pipelined_right_barrel_shifter_if.slave bus_if
);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    logic                   w_stall;

    logic [DATA_WIDTH-1:0]  w_in_data   [SHIFT_WIDTH];
    logic [SHIFT_WIDTH-1:0] w_in_shifts [SHIFT_WIDTH];
    logic                   w_in_arith  [SHIFT_WIDTH];
    logic                   w_in_valid  [SHIFT_WIDTH];
    logic                   w_fill      [SHIFT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_shifted   [SHIFT_WIDTH];
    logic [DATA_WIDTH-1:0]  w_next_data [SHIFT_WIDTH];

    logic [DATA_WIDTH-1:0]  r_data   [SHIFT_WIDTH];
    logic [SHIFT_WIDTH-1:0] r_shifts [SHIFT_WIDTH];
    logic                   r_arith  [SHIFT_WIDTH];
    logic                   r_valid  [SHIFT_WIDTH];
`ifdef RIGHT_SHIFT_ROUND_EN
    logic                   w_in_guard   [SHIFT_WIDTH];
    logic                   w_next_guard [SHIFT_WIDTH];
    logic                   r_guard      [SHIFT_WIDTH];
`endif

    // Only a held result can block the pipe; bubbles are not squeezed out.
    assign w_stall            = bus_if.out_valid_o & ~bus_if.out_ready_i;
    assign bus_if.in_ready_o  = ~w_stall;
    assign bus_if.out_valid_o = r_valid[SHIFT_WIDTH-1];
    assign bus_if.data_o      = r_data[SHIFT_WIDTH-1];

    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
        localparam int AMT = 2 ** k;

        if (k == 0) begin : g_head
            assign w_in_data[k]   = bus_if.data_i;
            assign w_in_shifts[k] = bus_if.shifts_i;
            assign w_in_arith[k]  = bus_if.arith_i;
            assign w_in_valid[k]  = bus_if.in_valid_i;
`ifdef RIGHT_SHIFT_ROUND_EN
            assign w_in_guard[k]  = 1'b0;
`endif
        end else begin : g_link
            assign w_in_data[k]   = r_data[k-1];
            assign w_in_shifts[k] = r_shifts[k-1];
            assign w_in_arith[k]  = r_arith[k-1];
            assign w_in_valid[k]  = r_valid[k-1];
`ifdef RIGHT_SHIFT_ROUND_EN
            assign w_in_guard[k]  = r_guard[k-1];
`endif
        end

        // A shift of AMT >= DATA_WIDTH leaves nothing but fill, which this expression yields directly.
        assign w_fill[k]    = w_in_arith[k] & w_in_data[k][DATA_WIDTH-1];
        assign w_shifted[k] = w_in_shifts[k][k]
                            ? ((w_in_data[k] >> AMT) | ({DATA_WIDTH{w_fill[k]}} & ~(ALL_ONES >> AMT)))
                            : w_in_data[k];

`ifdef RIGHT_SHIFT_ROUND_EN
        localparam int GUARD_IDX = (AMT <= DATA_WIDTH) ? AMT - 1 : 0;

        assign w_next_guard[k] = w_in_shifts[k][k]
                               ? ((AMT <= DATA_WIDTH) ? w_in_data[k][GUARD_IDX] : 1'b0)
                               : w_in_guard[k];

        if (k == SHIFT_WIDTH - 1) begin : g_round
            assign w_next_data[k] = w_shifted[k] + DATA_WIDTH'(w_next_guard[k]);
        end else begin : g_trunc
            assign w_next_data[k] = w_shifted[k];
        end
`else
        assign w_next_data[k] = w_shifted[k];
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < SHIFT_WIDTH; k++) begin
                r_valid[k]  <= 1'b0;
                r_data[k]   <= '0;
                r_shifts[k] <= '0;
                r_arith[k]  <= 1'b0;
`ifdef RIGHT_SHIFT_ROUND_EN
                r_guard[k]  <= 1'b0;
`endif
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SHIFT_WIDTH; k++) begin
                r_valid[k]  <= w_in_valid[k];
                r_data[k]   <= w_next_data[k];
                r_shifts[k] <= w_in_shifts[k];
                r_arith[k]  <= w_in_arith[k];
`ifdef RIGHT_SHIFT_ROUND_EN
                r_guard[k]  <= w_next_guard[k];
`endif
            end
        end
    end
endmodule

// File: tb/tb_pipelined_right_barrel_shifter.sv
// Bench for pipelined_right_barrel_shifter: directed spec cases plus randomized streams
// under backpressure, scored against an arithmetic reference model.
module tb_pipelined_right_barrel_shifter;
    localparam int DW        = 22;
    localparam int SW        = 5;
    localparam int MAX_SHIFT = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_right_barrel_shifter_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) u_if ();

    pipelined_right_barrel_shifter #(
        .DATA_WIDTH (DW),
        .SHIFT_WIDTH(SW)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_if(u_if)
    );

    int            n_checks;
    int            n_fail;
    logic [DW-1:0] exp_q[$];
    logic          stalled_prev;
    logic [DW-1:0] held_data;

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: divide by 2**s with floor on a sign- or zero-extended value.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input int s, input logic a);
        longint        v;
        longint        r;
        logic [DW-1:0] res;
`ifdef RIGHT_SHIFT_ROUND_EN
        logic          g;
        int            hp;
`endif
        v = longint'(d);
        if (a && d[DW-1]) v = v - (longint'(1) << DW);
        r   = v >>> s;
        res = r[DW-1:0];
`ifdef RIGHT_SHIFT_ROUND_EN
        if (s > 0) begin
            g  = v[s-1];
            hp = 1;
            while ((hp << 1) <= s) hp = hp << 1;
            if (hp > DW) g = 1'b0;
            res = res + {{(DW-1){1'b0}}, g};
        end
`endif
        return res;
    endfunction

    // Called at a negedge; drives one cycle, scores outputs, returns at the next negedge.
    task automatic drive_cycle(input logic iv, input logic [DW-1:0] d, input logic [SW-1:0] s,
                               input logic a, input logic ordy, output logic accepted);
        u_if.in_valid_i  = iv;
        u_if.data_i      = d;
        u_if.shifts_i    = s;
        u_if.arith_i     = a;
        u_if.out_ready_i = ordy;
        #1;
        check_eq("in_ready", u_if.in_ready_o, !(u_if.out_valid_o && !ordy));
        if (stalled_prev) begin
            check_eq("hold_valid", u_if.out_valid_o, 1'b1);
            check_eq("hold_data", u_if.data_o, held_data);
        end
        if (u_if.out_valid_o && ordy) begin
            if (exp_q.size() == 0) check_eq("spurious_out", u_if.out_valid_o, 1'b0);
            else check_eq("stream_data", u_if.data_o, exp_q.pop_front());
        end
        accepted = iv && u_if.in_ready_o;
        if (accepted) exp_q.push_back(model(d, int'(s), a));
        stalled_prev = u_if.out_valid_o && !ordy;
        held_data    = u_if.data_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input logic random_ready);
        logic acc;
        logic ordy;
        int   n;
        n = 0;
        while ((exp_q.size() != 0 || u_if.out_valid_o) && n < 300) begin
            ordy = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_cycle(1'b0, '0, '0, 1'b0, ordy, acc);
            n++;
        end
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    // Single word through an empty pipe; checks latency in edges and the spec's constant.
    task automatic run_directed(input string tag, input logic [DW-1:0] d, input logic [SW-1:0] s,
                                input logic a, input logic [DW-1:0] exp);
        int n;
        stalled_prev     = 1'b0;
        u_if.in_valid_i  = 1'b1;
        u_if.data_i      = d;
        u_if.shifts_i    = s;
        u_if.arith_i     = a;
        u_if.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        u_if.in_valid_i = 1'b0;
        n = 1;
        while (!u_if.out_valid_o && n < 4 * SW) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_lat"}, n, SW);
        check_eq(tag, u_if.data_o, exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic          acc;
        logic          ordy;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          a;
        int            k;
        int            guard;

        n_checks     = 0;
        n_fail       = 0;
        stalled_prev = 1'b0;
        held_data    = '0;

        // Reset with a word offered
        rst_n            = 1'b0;
        u_if.in_valid_i  = 1'b1;
        u_if.data_i      = 22'h155555;
        u_if.shifts_i    = 5'd3;
        u_if.arith_i     = 1'b1;
        u_if.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", u_if.out_valid_o, 1'b0);
        check_eq("rst_data_o", u_if.data_o, 22'h0);
        u_if.in_valid_i = 1'b0;
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", u_if.in_ready_o, 1'b1);
        @(negedge clk);

        run_directed("arith_sh2", 22'h3FFFF8, 5'd2, 1'b1, 22'h3FFFFE);
        run_directed("logic_sh2", 22'h3FFFF8, 5'd2, 1'b0, 22'h0FFFFE);
        run_directed("shift0", 22'h2ABCDE, 5'd0, 1'b1, 22'h2ABCDE);
`ifdef RIGHT_SHIFT_ROUND_EN
        run_directed("over_neg", 22'h200000, 5'd31, 1'b1, 22'h000000);
`else
        run_directed("over_neg", 22'h200000, 5'd31, 1'b1, 22'h3FFFFF);
`endif
        run_directed("over_pos", 22'h1FFFFF, 5'd31, 1'b1, 22'h000000);
        run_directed("over_log", 22'h3FFFFF, 5'd31, 1'b0, 22'h000000);
`ifdef RIGHT_SHIFT_ROUND_EN
        run_directed("rnd_7", 22'h000007, 5'd1, 1'b0, 22'h000004);
        run_directed("rnd_m7", 22'h3FFFF9, 5'd1, 1'b1, 22'h3FFFFD);
`else
        run_directed("rnd_7", 22'h000007, 5'd1, 1'b0, 22'h000003);
        run_directed("rnd_m7", 22'h3FFFF9, 5'd1, 1'b1, 22'h3FFFFC);
`endif
        run_directed("rnd_6", 22'h000006, 5'd1, 1'b0, 22'h000003);

        // 20 back-to-back words with random backpressure
        k     = 0;
        guard = 0;
        d     = DW'($urandom);
        s     = SW'($urandom_range(0, MAX_SHIFT));
        a     = 1'($urandom_range(0, 1));
        while (k < 20 && guard < 500) begin
            ordy = ($urandom_range(0, 3) != 0);
            drive_cycle(1'b1, d, s, a, ordy, acc);
            if (acc) begin
                k++;
                d = DW'($urandom);
                s = SW'($urandom_range(0, MAX_SHIFT));
                a = 1'($urandom_range(0, 1));
            end
            guard++;
        end
        check_eq("stream_pushed", k, 20);
        drain(1'b1);

        // Sparse random traffic with bubbles and backpressure
        for (int i = 0; i < 120; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), DW'($urandom), SW'($urandom_range(0, MAX_SHIFT)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), acc);
        end
        drain(1'b1);

        // Reset with words in flight
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, DW'($urandom), SW'($urandom_range(0, MAX_SHIFT)), 1'b1, 1'b1, acc);
        end
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
        check_eq("mid_pre_valid", u_if.out_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", u_if.out_valid_o, 1'b0);
        exp_q.delete();
        stalled_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 22'h2468AC, 5'd4, 1'b0, 1'b1, acc);
        check_eq("post_rst_accept", acc, 1'b1);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
